// File: rtl/dlx_pkg.sv
// dlx_pkg: shared definitions for the DLX control slice.
//   - seq_state_t      : sequencer state encoding
//   - TIMEOUT_DEFAULT  : default memory-handshake watchdog limit
//   - OP_*             : decoder primary opcode constants
//   - is_wait_state()  : true for the states that wait on a memory ack
package dlx_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } seq_state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQZ    = 6'h04;
  localparam logic [5:0] OP_BNEZ    = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // States in which the shared watchdog runs.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == S_IF) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/dlx_wait_timer.sv
// dlx_wait_timer: cycle counter for a pending memory request.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : clear the count (asserted while not waiting)
//   en           : request outstanding with no ack this cycle
//   expire       : last permitted wait cycle passed without an ack
module dlx_wait_timer
  import dlx_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_r;

  // Wait-cycle counter; cleared whenever the sequencer is not waiting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // An ack in the final cycle drops en, so the ack wins over expiry.
  assign expire = en && (count_r == LAST);

endmodule

// File: rtl/dlx_sequencer.sv
// dlx_sequencer: multi-cycle IF/ID/EX/MEM/WB control FSM for the DLX core.
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   run                  : start fetching (sampled in IDLE and WB only)
//   i_ack, d_ack         : instruction / data memory acknowledges
//   load_en, store_en, rd: registered decoder outputs, valid from EX on
//   i_req, d_req, d_we   : memory requests and data write qualifier
//   id_en, ex_en, wb_en  : phase strobes (one-hot while busy)
//   reg_we, pc_en        : register-file write and PC update, WB only
//   busy, bus_err        : activity flag and sticky watchdog error
//   retired              : count of completed instructions
// All outputs are registers loaded from the next state, so they behave as
// Moore outputs of the state register with no combinational input path.
module dlx_sequencer
  import dlx_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        i_ack,
  input  logic        d_ack,
  input  logic        load_en,
  input  logic        store_en,
  input  logic [4:0]  rd,
  output logic        i_req,
  output logic        d_req,
  output logic        d_we,
  output logic        id_en,
  output logic        ex_en,
  output logic        wb_en,
  output logic        reg_we,
  output logic        pc_en,
  output logic        busy,
  output logic        bus_err,
  output logic [31:0] retired
);

  seq_state_t  state_r;
  seq_state_t  next_s;
  logic        store_r;
  logic        store_s;
  logic        wt_clr_s;
  logic        wt_en_s;
  logic        expire_s;

  logic        i_req_r, d_req_r, d_we_r, id_en_r, ex_en_r, wb_en_r;
  logic        reg_we_r, pc_en_r, busy_r, bus_err_r;
  logic [31:0] retired_r;

  dlx_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wt_clr_s),
    .en      (wt_en_s),
    .expire  (expire_s)
  );

  // Watchdog control: count only while a request is waiting for its ack.
  always_comb begin
    wt_clr_s = !is_wait_state(state_r);
    case (state_r)
      S_IF:    wt_en_s = !i_ack;
      S_MEM:   wt_en_s = !d_ack;
      default: wt_en_s = 1'b0;
    endcase
  end

  // Store qualifier: live decoder value in EX, captured copy afterwards.
  always_comb begin
    if (state_r == S_EX) begin
      store_s = store_en;
    end else begin
      store_s = store_r;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (run) next_s = S_IF;
        else     next_s = S_IDLE;
      end
      S_IF: begin
        if (i_ack)         next_s = S_ID;
        else if (expire_s) next_s = S_HALT;
        else               next_s = S_IF;
      end
      S_ID: next_s = S_EX;
      S_EX: begin
        if (load_en || store_en) next_s = S_MEM;
        else                     next_s = S_WB;
      end
      S_MEM: begin
        if (d_ack)         next_s = S_WB;
        else if (expire_s) next_s = S_HALT;
        else               next_s = S_MEM;
      end
      S_WB: begin
        if (run) next_s = S_IF;
        else     next_s = S_IDLE;
      end
      S_HALT:  next_s = S_HALT;
      default: next_s = S_IDLE;
    endcase
  end

  // State, captured store flag, registered strobes and retire counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      store_r   <= 1'b0;
      i_req_r   <= 1'b0;
      d_req_r   <= 1'b0;
      d_we_r    <= 1'b0;
      id_en_r   <= 1'b0;
      ex_en_r   <= 1'b0;
      wb_en_r   <= 1'b0;
      reg_we_r  <= 1'b0;
      pc_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      bus_err_r <= 1'b0;
      retired_r <= 32'd0;
    end else begin
      state_r   <= next_s;
      store_r   <= store_s;
      i_req_r   <= (next_s == S_IF);
      d_req_r   <= (next_s == S_MEM);
      d_we_r    <= (next_s == S_MEM) && store_s;
      id_en_r   <= (next_s == S_ID);
      ex_en_r   <= (next_s == S_EX);
      wb_en_r   <= (next_s == S_WB);
      // A load+store is treated as a store, so it never writes a register.
      reg_we_r  <= (next_s == S_WB) && (rd != 5'd0) && !store_s;
      pc_en_r   <= (next_s == S_WB);
      busy_r    <= (next_s != S_IDLE) && (next_s != S_HALT);
      bus_err_r <= (next_s == S_HALT);
      if (state_r == S_WB) begin
        retired_r <= retired_r + 32'd1;
      end
    end
  end

  assign i_req   = i_req_r;
  assign d_req   = d_req_r;
  assign d_we    = d_we_r;
  assign id_en   = id_en_r;
  assign ex_en   = ex_en_r;
  assign wb_en   = wb_en_r;
  assign reg_we  = reg_we_r;
  assign pc_en   = pc_en_r;
  assign busy    = busy_r;
  assign bus_err = bus_err_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_dlx_sequencer.sv
// tb_dlx_sequencer: randomized scoreboard bench for dlx_sequencer (TIMEOUT=4).
// The driver issues instructions and pushes a per-instruction summary
// (fetch wait, memory wait, write qualifier, register write, retire count)
// derived from the instruction parameters; the monitor accumulates what the
// DUT shows each cycle and compares it when the WB strobe appears.
module tb_dlx_sequencer;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset_n, run, i_ack, d_ack, load_en, store_en;
  logic [4:0]  rd;
  logic        i_req, d_req, d_we, id_en, ex_en, wb_en, reg_we, pc_en, busy, bus_err;
  logic [31:0] retired;

  always #5 clk = ~clk;

  dlx_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .i_ack(i_ack), .d_ack(d_ack),
    .load_en(load_en), .store_en(store_en), .rd(rd),
    .i_req(i_req), .d_req(d_req), .d_we(d_we), .id_en(id_en), .ex_en(ex_en),
    .wb_en(wb_en), .reg_we(reg_we), .pc_en(pc_en), .busy(busy),
    .bus_err(bus_err), .retired(retired)
  );

  typedef struct {
    int          i_cyc;
    int          d_cyc;
    bit          d_we;
    bit          reg_we;
    logic [31:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_ret;
  bit          mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    int m_i, m_id, m_ex, m_d, m_dwe, m_stray;
    bit ret_pend;
    logic [31:0] ret_exp;
    exp_t e;
    m_i = 0; m_id = 0; m_ex = 0; m_d = 0; m_dwe = 0; m_stray = 0;
    ret_pend = 1'b0; ret_exp = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset_n || !mon_en) begin
        m_i = 0; m_id = 0; m_ex = 0; m_d = 0; m_dwe = 0; m_stray = 0;
        ret_pend = 1'b0;
      end else begin
        if (ret_pend) begin
          check("retired_after_wb", retired, ret_exp);
          ret_pend = 1'b0;
        end
        // Exactly one phase strobe while busy, none otherwise.
        check("strobe_onehot", 32'($countones({i_req, id_en, ex_en, d_req, wb_en})), {31'd0, busy});
        if (i_req) m_i++;
        if (id_en) m_id++;
        if (ex_en) m_ex++;
        if (d_req) m_d++;
        if (d_req && d_we) m_dwe++;
        if (!d_req && d_we) m_stray++;
        if (!wb_en && (reg_we || pc_en)) m_stray++;
        if (wb_en) begin
          if (exp_q.size() == 0) begin
            check("wb_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("fetch_cycles", m_i, e.i_cyc);
            check("id_cycles", m_id, 1);
            check("ex_cycles", m_ex, 1);
            check("mem_cycles", m_d, e.d_cyc);
            check("d_we_cycles", m_dwe, e.d_we ? e.d_cyc : 0);
            check("reg_we", {31'd0, reg_we}, {31'd0, e.reg_we});
            check("pc_en", {31'd0, pc_en}, 32'd1);
            check("stray_strobes", m_stray, 0);
            ret_pend = 1'b1;
            ret_exp  = e.ret;
          end
          m_i = 0; m_id = 0; m_ex = 0; m_d = 0; m_dwe = 0; m_stray = 0;
        end
      end
    end
  end

  function automatic logic strobe(input int w);
    case (w)
      0:       return i_req;
      1:       return d_req;
      default: return wb_en;
    endcase
  endfunction

  task automatic wait_strobe(input int w, input string nm);
    int n = 0;
    while (strobe(w) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (strobe(w) !== 1'b1) check(nm, 32'd0, 32'd1);
  endtask

  // Hold the request for lat cycles, acking in the last one.
  task automatic ack_phase(input int w, input int lat);
    for (int c = 1; c <= lat; c++) begin
      if (w == 0) i_ack = (c == lat);
      else        d_ack = (c == lat);
      @(negedge clk);
    end
    i_ack = 1'b0;
    d_ack = 1'b0;
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 load+store (acts as store).
  task automatic do_instr(input int kind, input logic [4:0] r, input int il,
                          input int dl, input bit run_next);
    exp_t e;
    load_en  = (kind == 1) || (kind == 3);
    store_en = (kind == 2) || (kind == 3);
    rd       = r;
    model_ret = model_ret + 32'd1;
    e.i_cyc  = il;
    e.d_cyc  = (kind != 0) ? dl : 0;
    e.d_we   = store_en;
    e.reg_we = (r != 5'd0) && !store_en;
    e.ret    = model_ret;
    exp_q.push_back(e);
    run = 1'b1;
    wait_strobe(0, "wait_i_req");
    ack_phase(0, il);
    run = run_next;
    if (kind != 0) begin
      wait_strobe(1, "wait_d_req");
      ack_phase(1, dl);
    end
    wait_strobe(2, "wait_wb");
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_ret = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cnt;
    reset_n = 1'b0; run = 1'b0; i_ack = 1'b0; d_ack = 1'b0;
    load_en = 1'b0; store_en = 1'b0; rd = 5'd0; model_ret = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outs", {22'd0, i_req, d_req, d_we, id_en, ex_en, wb_en, reg_we, pc_en, busy, bus_err}, 32'd0);
    check("reset_retired", retired, 32'd0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_without_run", {31'd0, busy}, 32'd0);

    // Directed cases.
    do_instr(0, 5'd3, 1, 0, 1'b1);
    check("no_bubble_after_wb", {31'd0, i_req}, 32'd1);
    do_instr(1, 5'd5, 1, 3, 1'b1);
    do_instr(2, 5'd0, 2, 2, 1'b1);
    do_instr(3, 5'd7, 1, 1, 1'b1);
    do_instr(0, 5'd9, 1, 0, 1'b0);
    check("run_drop_idle_busy", {31'd0, busy}, 32'd0);
    check("run_drop_retired", retired, model_ret);
    @(negedge clk);
    check("run_drop_stays_idle", {31'd0, i_req}, 32'd0);

    // Randomized instruction stream; waits stay within the watchdog limit.
    for (int k = 0; k < 40; k++) begin
      do_instr(int'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
               int'($urandom_range(1, TO)), int'($urandom_range(1, TO)),
               $urandom_range(0, 4) != 0);
    end

    // Fetch watchdog: no i_ack at all.
    do_reset();
    run = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (i_req) cnt++;
    end
    check("wd_fetch_req_cycles", cnt, TO);
    check("wd_fetch_bus_err", {31'd0, bus_err}, 32'd1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_err && !busy && !i_req) cnt++;
    end
    check("halt_held_20", cnt, 20);
    do_reset();
    check("bus_err_cleared", {31'd0, bus_err}, 32'd0);

    // Ack in the last permitted cycle wins.
    do_instr(0, 5'd1, TO, 0, 1'b0);
    check("ack_last_cycle_no_err", {31'd0, bus_err}, 32'd0);
    do_instr(1, 5'd2, 1, TO, 1'b0);
    check("dack_last_cycle_no_err", {31'd0, bus_err}, 32'd0);

    // Data watchdog: no d_ack.
    do_reset();
    load_en = 1'b1; store_en = 1'b0; rd = 5'd4;
    run = 1'b1;
    wait_strobe(0, "wd_mem_wait_i_req");
    ack_phase(0, 1);
    run = 1'b0;
    wait_strobe(1, "wd_mem_wait_d_req");
    cnt = 0;
    repeat (30) begin
      if (d_req) cnt++;
      @(negedge clk);
    end
    check("wd_mem_req_cycles", cnt, TO);
    check("wd_mem_bus_err", {31'd0, bus_err}, 32'd1);

    // Reset in the middle of a data request.
    do_reset();
    do_instr(0, 5'd2, 1, 0, 1'b1);
    load_en = 1'b1; store_en = 1'b0; rd = 5'd6;
    ack_phase(0, 1);
    wait_strobe(1, "rst_mem_wait_d_req");
    @(negedge clk);
    check("rst_mem_d_req_before", {31'd0, d_req}, 32'd1);
    reset_n = 1'b0;
    run = 1'b0;
    @(negedge clk);
    check("rst_mem_outs", {22'd0, i_req, d_req, d_we, id_en, ex_en, wb_en, reg_we, pc_en, busy, bus_err}, 32'd0);
    check("rst_mem_retired", retired, 32'd0);
    reset_n = 1'b1;
    model_ret = 32'd0;
    @(negedge clk);

    // Recovery after reset.
    do_instr(1, 5'd4, 2, 1, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
